// File: rtl/chip8_mem_arbiter_pkg.sv
// Shared constants and encodings for the CHIP-8 RAM arbiter slice.
package chip8_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    OWN_LD  = 2'd0,
    OWN_CPU = 2'd1,
    OWN_VID = 2'd2
  } own_e;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// Requester handshakes plus RAM pins; slave = arbiter side, master = requesters/RAM side.
interface chip8_mem_arbiter_if;
  import chip8_pkg::*;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_lock;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    input  vid_req, vid_addr,
    input  mem_rdata,
    output ld_gnt, cpu_gnt, vid_gnt,
    output ld_rvalid, cpu_rvalid, vid_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    output vid_req, vid_addr,
    output mem_rdata,
    input  ld_gnt, cpu_gnt, vid_gnt,
    input  ld_rvalid, cpu_rvalid, vid_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/chip8_mem_arbiter_starve_cnt.sv
// Saturating count of cycles the video requester has been kept waiting.
module chip8_starve_cnt
  import chip8_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_i,
  input  logic              gnt_i,
  output logic [WAIT_W-1:0] cnt_o
);

  localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Clear when idle or served, otherwise count up and stick at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = {WAIT_W{1'b0}};
    end else if (cnt_q == MAX_C) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {WAIT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Three-way arbiter for the single-port CHIP-8 RAM: combinational grant,
// registered RAM command, and owner-tagged read return one cycle after the command.
module chip8_mem_arbiter
  import chip8_pkg::*;
#(
  parameter int unsigned VID_MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  chip8_mem_arbiter_if.slave  bus
);

  localparam logic [WAIT_W-1:0] VID_MAX_C = WAIT_W'(VID_MAX_WAIT);

  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] vid_wait_s;
  logic              vid_starve_s;

  logic              ld_gnt_s;
  logic              cpu_gnt_s;
  logic              vid_gnt_s;
  logic              any_gnt_s;

  own_e              sel_own_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  own_e              cmd_own_q;
  logic              ret_valid_q;
  own_e              ret_own_q;

  chip8_starve_cnt #(
    .MAX_WAIT (VID_MAX_WAIT)
  ) u_starve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (bus.vid_req),
    .gnt_i   (vid_gnt_s),
    .cnt_o   (vid_wait_s)
  );

  assign vid_starve_s = (vid_wait_s == VID_MAX_C);

  // Grant selection and lock FSM; while reset_n is low every grant is forced off.
  always_comb begin
    ld_gnt_s  = 1'b0;
    cpu_gnt_s = 1'b0;
    vid_gnt_s = 1'b0;
    state_d   = state_q;
    if (!reset_n) begin
      state_d = ARB;
    end else begin
      case (state_q)
        ARB: begin
          if (bus.ld_req) begin
            ld_gnt_s = 1'b1;
          end else if (bus.vid_req && vid_starve_s) begin
            vid_gnt_s = 1'b1;
          end else if (bus.cpu_req) begin
            cpu_gnt_s = 1'b1;
            if (bus.cpu_lock) begin
              state_d = LOCKED;
            end else begin
              state_d = ARB;
            end
          end else if (bus.vid_req) begin
            vid_gnt_s = 1'b1;
          end else begin
            state_d = ARB;
          end
        end
        LOCKED: begin
          // Lock release is independent of whether the CPU is requesting this cycle.
          cpu_gnt_s = bus.cpu_req;
          if (!bus.cpu_lock) begin
            state_d = ARB;
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d = ARB;
        end
      endcase
    end
  end

  assign any_gnt_s = ld_gnt_s | cpu_gnt_s | vid_gnt_s;

  // Route the granted requester's command fields toward the command register.
  always_comb begin
    sel_own_s   = OWN_CPU;
    sel_we_s    = bus.cpu_we;
    sel_addr_s  = bus.cpu_addr;
    sel_wdata_s = bus.cpu_wdata;
    if (ld_gnt_s) begin
      sel_own_s   = OWN_LD;
      sel_we_s    = bus.ld_we;
      sel_addr_s  = bus.ld_addr;
      sel_wdata_s = bus.ld_wdata;
    end else if (vid_gnt_s) begin
      sel_own_s   = OWN_VID;
      sel_we_s    = 1'b0;
      sel_addr_s  = bus.vid_addr;
      sel_wdata_s = mem_wdata_q;
    end else begin
      sel_own_s   = OWN_CPU;
    end
  end

  // State, RAM command and read-return pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      cmd_own_q   <= OWN_LD;
      ret_valid_q <= 1'b0;
      ret_own_q   <= OWN_LD;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= any_gnt_s;
      mem_we_q    <= any_gnt_s & sel_we_s;
      if (any_gnt_s) begin
        mem_addr_q  <= sel_addr_s;
        mem_wdata_q <= sel_wdata_s;
        cmd_own_q   <= sel_own_s;
      end
      ret_valid_q <= mem_en_q & ~mem_we_q;
      ret_own_q   <= cmd_own_q;
    end
  end

  assign bus.ld_gnt     = ld_gnt_s;
  assign bus.cpu_gnt    = cpu_gnt_s;
  assign bus.vid_gnt    = vid_gnt_s;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  // RAM data arrives a cycle after the strobe, so it is passed straight through.
  assign bus.rdata      = ret_valid_q ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.ld_rvalid  = ret_valid_q && (ret_own_q == OWN_LD);
  assign bus.cpu_rvalid = ret_valid_q && (ret_own_q == OWN_CPU);
  assign bus.vid_rvalid = ret_valid_q && (ret_own_q == OWN_VID);

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Self-checking bench for chip8_mem_arbiter: directed scenarios plus a randomized
// run, all compared against a cycle-level reference model of the arbitration rules.
module tb_chip8_mem_arbiter;
  import chip8_pkg::*;

  localparam int unsigned MAXW = 4;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [1:0]  own;
    logic [7:0]  data;
  } cmd_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  chip8_mem_arbiter_if bus();

  chip8_mem_arbiter #(.VID_MAX_WAIT(MAXW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ram     [0:4095];
  logic [7:0] ref_mem [0:4095];

  // RAM macro: synchronous read-first single port.
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  logic [2:0] gv;
  logic [2:0] rv;
  assign gv = {bus.vid_gnt, bus.cpu_gnt, bus.ld_gnt};
  assign rv = {bus.vid_rvalid, bus.cpu_rvalid, bus.ld_rvalid};

  // Reference model: lock flag, video wait count, command on the pins, return due now.
  bit          m_locked;
  int unsigned m_wait;
  cmd_t        m_cmd;
  cmd_t        m_ret;

  function automatic logic [2:0] exp_gnt();
    if (reset_n !== 1'b1) return 3'b000;
    if (m_locked) return (bus.cpu_req === 1'b1) ? 3'b010 : 3'b000;
    if (bus.ld_req === 1'b1) return 3'b001;
    if (bus.vid_req === 1'b1 && m_wait >= MAXW) return 3'b100;
    if (bus.cpu_req === 1'b1) return 3'b010;
    if (bus.vid_req === 1'b1) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_rv();
    return m_ret.en ? (3'b001 << m_ret.own) : 3'b000;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_wait   = 0;
    m_cmd    = '0;
    m_ret    = '0;
  endtask

  task automatic model_step();
    logic [2:0] g;
    cmd_t nc;
    g = exp_gnt();
    m_ret      = '0;
    m_ret.en   = m_cmd.en && !m_cmd.we;
    m_ret.own  = m_cmd.own;
    m_ret.data = m_cmd.data;
    nc    = m_cmd;
    nc.en = 1'b0;
    nc.we = 1'b0;
    if (g == 3'b001) begin
      nc.en = 1'b1; nc.we = bus.ld_we; nc.addr = bus.ld_addr; nc.wdata = bus.ld_wdata; nc.own = OWN_LD;
    end else if (g == 3'b010) begin
      nc.en = 1'b1; nc.we = bus.cpu_we; nc.addr = bus.cpu_addr; nc.wdata = bus.cpu_wdata; nc.own = OWN_CPU;
    end else if (g == 3'b100) begin
      nc.en = 1'b1; nc.we = 1'b0; nc.addr = bus.vid_addr; nc.own = OWN_VID;
    end
    if (nc.en) begin
      nc.data = ref_mem[nc.addr];
      if (nc.we) ref_mem[nc.addr] = nc.wdata;
    end
    m_cmd = nc;
    if (bus.vid_req === 1'b1 && g != 3'b100) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
    else m_wait = 0;
    m_locked = m_locked ? (bus.cpu_lock === 1'b1) : (g == 3'b010 && bus.cpu_lock === 1'b1);
  endtask

  // Called at the falling edge after comparisons; returns just after the next rising edge.
  task automatic step();
    if (reset_n === 1'b1) model_step();
    else model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_req = 1'b0; bus.cpu_req = 1'b0; bus.vid_req = 1'b0; bus.cpu_lock = 1'b0;
    bus.ld_we = 1'b0; bus.cpu_we = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.ld_req = 1'b1; bus.cpu_req = 1'b1; bus.vid_req = 1'b1;
    @(negedge clk);
    checks++; if (gv !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gv); end
    checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_strobe: en=%b we=%b want 0 0", bus.mem_en, bus.mem_we); end
    checks++; if (bus.mem_addr !== 12'h000 || bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_cmd: addr=%h wdata=%h want 000 00", bus.mem_addr, bus.mem_wdata); end
    checks++; if (rv !== 3'b000 || bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_ret: rvalid=%b rdata=%h want 000 00", rv, bus.rdata); end
    idle();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_cpu_read();
    idle();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
    @(negedge clk);
    checks++; if (gv !== 3'b010) begin errors++; $display("FAIL cpu_read_gnt: got %b want 010", gv); end
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h200) begin errors++; $display("FAIL cpu_read_cmd: en=%b we=%b addr=%h want 1 0 200", bus.mem_en, bus.mem_we, bus.mem_addr); end
    checks++; if (rv !== 3'b000) begin errors++; $display("FAIL cpu_read_early: rvalid=%b want 000", rv); end
    step();
    @(negedge clk);
    checks++; if (rv !== 3'b010 || bus.rdata !== 8'hA2) begin errors++; $display("FAIL cpu_read_ret: rvalid=%b rdata=%h want 010 a2", rv, bus.rdata); end
    step();
    drain(1);
  endtask

  task automatic test_ld_priority();
    idle();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h201;
    for (int c = 0; c < 4; c++) begin
      bus.ld_req   = (c < 3);
      bus.ld_we    = 1'b1;
      bus.ld_addr  = 12'($urandom_range(0, 255));
      bus.ld_wdata = 8'($urandom);
      @(negedge clk);
      checks++;
      if (gv !== ((c < 3) ? 3'b001 : 3'b010)) begin errors++; $display("FAIL ld_priority c%0d: got %b want %b", c, gv, (c < 3) ? 3'b001 : 3'b010); end
      step();
    end
    idle();
    drain(2);
  endtask

  task automatic test_starvation();
    idle();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    bus.vid_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.cpu_addr = 12'h400 + 12'(k);
      bus.vid_addr = 12'h800 + 12'(k);
      @(negedge clk);
      checks++;
      if (gv !== ((k == 4 || k == 9) ? 3'b100 : 3'b010)) begin errors++; $display("FAIL starve k%0d: got %b want %b", k, gv, (k == 4 || k == 9) ? 3'b100 : 3'b010); end
      step();
    end
    idle();
    drain(2);
  endtask

  task automatic test_burst_lock();
    logic [2:0] want_g;
    logic [2:0] want_r;
    idle();
    bus.vid_req = 1'b1; bus.vid_addr = 12'h900;
    for (int c = 0; c < 7; c++) begin
      bus.cpu_req  = (c < 4);
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 12'h300 + 12'(c);
      bus.cpu_lock = (c < 3);
      bus.vid_req  = (c < 5);
      @(negedge clk);
      want_g = (c < 4) ? 3'b010 : ((c == 4) ? 3'b100 : 3'b000);
      want_r = (c >= 2 && c <= 5) ? 3'b010 : ((c == 6) ? 3'b100 : 3'b000);
      checks++; if (gv !== want_g) begin errors++; $display("FAIL burst_gnt c%0d: got %b want %b", c, gv, want_g); end
      checks++; if (rv !== want_r) begin errors++; $display("FAIL burst_rvalid c%0d: got %b want %b", c, rv, want_r); end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (bus.rdata !== 8'hE0 + 8'(c - 2)) begin errors++; $display("FAIL burst_data c%0d: got %h want %h", c, bus.rdata, 8'hE0 + 8'(c - 2)); end
      end
      step();
    end
    idle();
    drain(1);
  endtask

  task automatic test_write_read();
    idle();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h3FF; bus.cpu_wdata = 8'h55;
    @(negedge clk);
    checks++; if (gv !== 3'b010) begin errors++; $display("FAIL wr_gnt: got %b want 010", gv); end
    step();
    bus.cpu_we = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 12'h3FF || bus.mem_wdata !== 8'h55) begin errors++; $display("FAIL wr_cmd: en=%b we=%b addr=%h wdata=%h want 1 1 3ff 55", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || rv !== 3'b000) begin errors++; $display("FAIL wr_no_rvalid: en=%b we=%b rvalid=%b want 1 0 000", bus.mem_en, bus.mem_we, rv); end
    step();
    @(negedge clk);
    checks++; if (rv !== 3'b010 || bus.rdata !== 8'h55) begin errors++; $display("FAIL rd_after_wr: rvalid=%b rdata=%h want 010 55", rv, bus.rdata); end
    step();
    drain(1);
  endtask

  task automatic test_reset_mid();
    idle();
    bus.vid_req = 1'b1; bus.vid_addr = 12'h200;
    @(negedge clk);
    checks++; if (gv !== 3'b100) begin errors++; $display("FAIL rstmid_gnt: got %b want 100", gv); end
    step();
    bus.vid_req = 1'b0;
    reset_n = 1'b0;
    bus.cpu_req = 1'b1;
    #1;
    checks++; if (gv !== 3'b000 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_async: gnt=%b en=%b we=%b want 000 0 0", gv, bus.mem_en, bus.mem_we); end
    checks++; if (bus.mem_addr !== 12'h000 || rv !== 3'b000 || bus.rdata !== 8'h00) begin errors++; $display("FAIL rstmid_regs: addr=%h rvalid=%b rdata=%h want 000 000 00", bus.mem_addr, rv, bus.rdata); end
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rv !== 3'b000) begin errors++; $display("FAIL rstmid_discard i%0d: rvalid=%b want 000", i, rv); end
      step();
    end
  endtask

  task automatic test_random();
    logic [2:0] g;
    idle();
    for (int n = 0; n < 500; n++) begin
      if (bus.ld_req !== 1'b1 && !m_locked && $urandom_range(0, 15) == 0) begin
        bus.ld_req = 1'b1; bus.ld_we = 1'($urandom); bus.ld_addr = 12'($urandom); bus.ld_wdata = 8'($urandom);
      end
      if (bus.cpu_req !== 1'b1 && $urandom_range(0, 1) == 0) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom); bus.cpu_addr = 12'($urandom); bus.cpu_wdata = 8'($urandom);
      end
      if (bus.vid_req !== 1'b1 && $urandom_range(0, 2) == 0) begin
        bus.vid_req = 1'b1; bus.vid_addr = 12'($urandom);
      end
      if ($urandom_range(0, 3) == 0) bus.cpu_lock = ~bus.cpu_lock;
      @(negedge clk);
      g = exp_gnt();
      checks++; if (gv !== g) begin errors++; $display("FAIL rnd_gnt n%0d: got %b want %b", n, gv, g); end
      checks++; if (bus.mem_en !== m_cmd.en || bus.mem_we !== m_cmd.we || bus.mem_addr !== m_cmd.addr) begin errors++; $display("FAIL rnd_cmd n%0d: en=%b we=%b addr=%h want %b %b %h", n, bus.mem_en, bus.mem_we, bus.mem_addr, m_cmd.en, m_cmd.we, m_cmd.addr); end
      if (m_cmd.en && m_cmd.we) begin
        checks++; if (bus.mem_wdata !== m_cmd.wdata) begin errors++; $display("FAIL rnd_wdata n%0d: got %h want %h", n, bus.mem_wdata, m_cmd.wdata); end
      end
      checks++; if (rv !== exp_rv()) begin errors++; $display("FAIL rnd_rvalid n%0d: got %b want %b", n, rv, exp_rv()); end
      if (m_ret.en) begin
        checks++; if (bus.rdata !== m_ret.data) begin errors++; $display("FAIL rnd_rdata n%0d: got %h want %h", n, bus.rdata, m_ret.data); end
      end
      step();
      if (g[0]) bus.ld_req = 1'b0;
      if (g[1]) bus.cpu_req = 1'b0;
      if (g[2]) bus.vid_req = 1'b0;
    end
    idle();
    drain(3);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[12'h200] = 8'hA2; ref_mem[12'h200] = 8'hA2;
    for (int k = 0; k < 4; k++) begin
      ram[12'h300 + 12'(k)]     = 8'hE0 + 8'(k);
      ref_mem[12'h300 + 12'(k)] = 8'hE0 + 8'(k);
    end
    idle();
    bus.ld_addr = 12'h000; bus.ld_wdata = 8'h00;
    bus.cpu_addr = 12'h000; bus.cpu_wdata = 8'h00; bus.vid_addr = 12'h000;
    model_reset();
    test_reset();
    test_cpu_read();
    test_ld_priority();
    test_starvation();
    test_burst_lock();
    test_write_read();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
